// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : riscv_pkg
//  Purpose : Shared types for the cache write path. It defines the direct
//            write request record and the encoding of the source that owns
//            the cache write port in a given cycle.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package riscv_pkg;

    localparam int unsigned RV_XLEN = 32;
    localparam int unsigned RV_BE_W = RV_XLEN / 8;

    // One direct (store) write request as seen by the cache write port.
    typedef struct packed {
        logic [RV_XLEN-1:0] addr;
        logic [RV_XLEN-1:0] data;
        logic [RV_BE_W-1:0] be;
    } cache_write_req_t;

    // Owner of the cache write port in the current cycle.
    typedef enum logic [1:0] {
        WR_SRC_NONE   = 2'd0,
        WR_SRC_DIRECT = 2'd1,
        WR_SRC_FILL   = 2'd2
    } wr_src_e;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/cache_fill_queue.sv
`default_nettype none
// ============================================================================
//  Module  : cache_fill_queue
//  Purpose : In-order FIFO of deferred load-miss fills. Each entry carries a
//            kill bit. A direct store to the same cache index sets that bit
//            without removing the entry, so ordering is never disturbed and a
//            killed entry simply pops without producing a write.
//  Ports   : i_clk, i_rst_n      clock, asynchronous active-low reset
//            i_flush             drop every entry (beats a same-cycle push)
//            i_push/_addr/_data  enqueue one fill
//            i_pop               retire the head entry
//            i_kill_en/_index    kill every entry at this index, including
//                                the entry being pushed this cycle
//            o_head_*            head entry (valid = slot occupied,
//                                live = occupied and not killed)
//            o_occupancy         occupied slots, killed entries included
//            o_live_count        occupied slots that are not killed
//  Rev     : 1.0  initial release
// ============================================================================
module cache_fill_queue
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int IndexWidth = 7,
    parameter int Depth      = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [XLEN-1:0]            i_push_addr,
    input  logic [XLEN-1:0]            i_push_data,
    input  logic                       i_pop,
    input  logic                       i_kill_en,
    input  logic [IndexWidth-1:0]      i_kill_index,
    output logic                       o_head_valid,
    output logic                       o_head_live,
    output logic [XLEN-1:0]            o_head_addr,
    output logic [XLEN-1:0]            o_head_data,
    output logic [$clog2(Depth+1)-1:0] o_occupancy,
    output logic [$clog2(Depth+1)-1:0] o_live_count
);

    localparam int PTR_W = $clog2(Depth);
    localparam int CNT_W = $clog2(Depth + 1);
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(Depth);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_occ;
    logic [Depth-1:0] r_valid;
    logic [Depth-1:0] r_kill;
    logic [XLEN-1:0]  r_addr [Depth];
    logic [XLEN-1:0]  r_data [Depth];

    logic             w_do_pop;
    logic             w_do_push;
    logic             w_push_kill;
    logic [Depth-1:0] w_match;
    logic [Depth-1:0] w_live;
    logic [Depth-1:0] w_valid_nxt;
    logic [Depth-1:0] w_kill_nxt;
    logic [CNT_W-1:0] w_live_cnt;

    // A full queue still accepts a push when the head leaves the same cycle;
    // the freed slot is the one the write pointer addresses.
    assign w_do_pop    = i_pop && (r_occ != '0);
    assign w_do_push   = i_push && !i_flush && ((r_occ < c_DEPTH) || w_do_pop);
    assign w_push_kill = i_kill_en && (i_push_addr[2 +: IndexWidth] == i_kill_index);

    for (genvar e = 0; e < Depth; e++) begin : g_entry
        assign w_match[e] = r_valid[e] && (r_addr[e][2 +: IndexWidth] == i_kill_index);
        assign w_live[e]  = r_valid[e] && !r_kill[e];
    end

    // Kill, then pop, then push: a push into the slot being vacated must win.
    always_comb begin
        w_valid_nxt = r_valid;
        w_kill_nxt  = r_kill;
        if (i_kill_en) begin
            w_kill_nxt = r_kill | w_match;
        end
        if (w_do_pop) begin
            w_valid_nxt[r_rd_ptr] = 1'b0;
            w_kill_nxt[r_rd_ptr]  = 1'b0;
        end
        if (w_do_push) begin
            w_valid_nxt[r_wr_ptr] = 1'b1;
            w_kill_nxt[r_wr_ptr]  = w_push_kill;
        end
    end

    always_comb begin
        w_live_cnt = '0;
        for (int i = 0; i < Depth; i++) begin
            w_live_cnt = w_live_cnt + CNT_W'(w_live[i]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_valid  <= '0;
            r_kill   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_valid  <= '0;
            r_kill   <= '0;
        end else begin
            // Depth is a power of two, so the pointers wrap by overflow.
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_do_push);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_do_pop);
            r_occ    <= r_occ + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
            r_valid  <= w_valid_nxt;
            r_kill   <= w_kill_nxt;
        end
    end

    // Payload storage is qualified by the valid bits and needs no reset.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_addr[r_wr_ptr] <= i_push_addr;
            r_data[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head_valid = (r_occ != '0);
    assign o_head_live  = w_live[r_rd_ptr];
    assign o_head_addr  = r_addr[r_rd_ptr];
    assign o_head_data  = r_data[r_rd_ptr];
    assign o_occupancy  = r_occ;
    assign o_live_count = w_live_cnt;

endmodule : cache_fill_queue
`default_nettype wire

// File: rtl/cache_write_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : cache_write_sequencer
//  Purpose : Owns the single cache write port. Direct stores from NumPorts
//            requesters are arbitrated by fixed priority (port 0 first) and
//            written in the same cycle. Load-miss fills are deferred through
//            cache_fill_queue and drained only in cycles without a direct
//            grant. A granted store kills queued fills to its index so that
//            stale fill data can never overwrite newer store data.
//  Ports   : i_clk, i_rst_n            clock, asynchronous active-low reset
//            i_stall                    blocks fill drain
//            i_flush                    discards all queued fills
//            i_wr_valid/addr/data/be    direct write request per port
//            o_wr_ready                 port granted or dropped this cycle
//            i_fill_valid/addr/data     fill push; o_fill_ready accepts it
//            i_cache_read_tag/valid     cache state at the direct write index
//            o_cache_write_*            cache write port
//            o_fill_count               live (not killed) queued fills
//  Rev     : 1.0  initial release
// ============================================================================
module cache_write_sequencer
    import riscv_pkg::*;
#(
    parameter int              XLEN            = 32,
    parameter int              CacheIndexWidth = 7,
    parameter int              CacheTagWidth   = 7,
    parameter int              NumPorts        = 3,
    parameter int              FillDepth       = 4,
    parameter logic [XLEN-1:0] MMIO_ADDR       = 32'h4000_0000
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_stall,
    input  logic                                i_flush,
    input  logic [NumPorts-1:0]                 i_wr_valid,
    input  logic [NumPorts-1:0][XLEN-1:0]       i_wr_addr,
    input  logic [NumPorts-1:0][XLEN-1:0]       i_wr_data,
    input  logic [NumPorts-1:0][XLEN/8-1:0]     i_wr_be,
    output logic [NumPorts-1:0]                 o_wr_ready,
    input  logic                                i_fill_valid,
    input  logic [XLEN-1:0]                     i_fill_addr,
    input  logic [XLEN-1:0]                     i_fill_data,
    output logic                                o_fill_ready,
    input  logic [CacheTagWidth-1:0]            i_cache_read_tag,
    input  logic [XLEN/8-1:0]                   i_cache_read_valid,
    output logic                                o_cache_write_enable,
    output logic [XLEN/8-1:0]                   o_cache_byte_write_enable,
    output logic [CacheIndexWidth-1:0]          o_cache_write_index,
    output logic [XLEN-1:0]                     o_cache_write_data,
    output logic [CacheTagWidth-1:0]            o_cache_write_tag,
    output logic [XLEN/8-1:0]                   o_cache_write_valid,
    output logic [$clog2(FillDepth+1)-1:0]      o_fill_count
);

    localparam int BE_W  = XLEN / 8;
    localparam int CNT_W = $clog2(FillDepth + 1);
    localparam int TAG_LSB = 2 + CacheIndexWidth;
    localparam logic [CNT_W-1:0] c_FILL_DEPTH = CNT_W'(FillDepth);

    logic [NumPorts-1:0]        w_cacheable;
    logic [NumPorts-1:0]        w_drop;
    logic [NumPorts-1:0]        w_grant;
    logic                       w_grant_any;
    cache_write_req_t           w_dir_req;
    logic [CacheIndexWidth-1:0] w_dir_index;
    logic [CacheTagWidth-1:0]   w_dir_tag;

    logic                       w_push;
    logic                       w_pop;
    logic                       w_head_valid;
    logic                       w_head_live;
    logic [XLEN-1:0]            w_head_addr;
    logic [XLEN-1:0]            w_head_data;
    logic [CNT_W-1:0]           w_occ;
    wr_src_e                    w_src;
    logic                       w_unused_addr;

    // ------------------------------------------------------------------
    // Direct-write arbitration
    // ------------------------------------------------------------------
    // MMIO and zero-byte-enable requests need no cache update; they are
    // acknowledged immediately so the requester is never held up by them.
    for (genvar p = 0; p < NumPorts; p++) begin : g_port
        assign w_cacheable[p] = i_wr_valid[p] && (|i_wr_be[p]) && (i_wr_addr[p] < MMIO_ADDR);
        assign w_drop[p]      = i_wr_valid[p] && !w_cacheable[p];
    end

    always_comb begin
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_dir_req   = '0;
        for (int p = 0; p < NumPorts; p++) begin
            if (w_cacheable[p] && !w_grant_any) begin
                w_grant[p]     = 1'b1;
                w_grant_any    = 1'b1;
                w_dir_req.addr = i_wr_addr[p];
                w_dir_req.data = i_wr_data[p];
                w_dir_req.be   = i_wr_be[p];
            end
        end
    end

    assign o_wr_ready  = w_grant | w_drop;
    assign w_dir_index = w_dir_req.addr[2 +: CacheIndexWidth];
    assign w_dir_tag   = w_dir_req.addr[TAG_LSB +: CacheTagWidth];

    // ------------------------------------------------------------------
    // Fill queue
    // ------------------------------------------------------------------
    // Drain only when the write port is otherwise idle; a flush cycle never
    // drains since everything queued is being discarded.
    assign w_pop        = !w_grant_any && !i_stall && !i_flush && w_head_valid;
    assign o_fill_ready = (w_occ < c_FILL_DEPTH) || w_pop;
    // MMIO fills complete the handshake but are never stored.
    assign w_push       = i_fill_valid && o_fill_ready && (i_fill_addr < MMIO_ADDR);

    cache_fill_queue #(
        .XLEN       (XLEN),
        .IndexWidth (CacheIndexWidth),
        .Depth      (FillDepth)
    ) u_fill_queue (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (i_flush),
        .i_push       (w_push),
        .i_push_addr  (i_fill_addr),
        .i_push_data  (i_fill_data),
        .i_pop        (w_pop),
        .i_kill_en    (w_grant_any),
        .i_kill_index (w_dir_index),
        .o_head_valid (w_head_valid),
        .o_head_live  (w_head_live),
        .o_head_addr  (w_head_addr),
        .o_head_data  (w_head_data),
        .o_occupancy  (w_occ),
        .o_live_count (o_fill_count)
    );

    // ------------------------------------------------------------------
    // Cache write port
    // ------------------------------------------------------------------
    always_comb begin
        if (w_grant_any) begin
            w_src = WR_SRC_DIRECT;
        end else if (w_pop && w_head_live) begin
            w_src = WR_SRC_FILL;
        end else begin
            w_src = WR_SRC_NONE;
        end
    end

    always_comb begin
        o_cache_byte_write_enable = '0;
        o_cache_write_index       = '0;
        o_cache_write_data        = '0;
        o_cache_write_tag         = '0;
        o_cache_write_valid       = '0;
        unique case (w_src)
            WR_SRC_DIRECT: begin
                o_cache_byte_write_enable = w_dir_req.be;
                o_cache_write_index       = w_dir_index;
                o_cache_write_data        = w_dir_req.data;
                o_cache_write_tag         = w_dir_tag;
                // Same line already resident: keep its valid bytes. A tag
                // change replaces the line, so only the stored bytes are valid.
                o_cache_write_valid       = (i_cache_read_tag == w_dir_tag)
                                          ? (w_dir_req.be | i_cache_read_valid)
                                          : w_dir_req.be;
            end
            WR_SRC_FILL: begin
                o_cache_byte_write_enable = {BE_W{1'b1}};
                o_cache_write_index       = w_head_addr[2 +: CacheIndexWidth];
                o_cache_write_data        = w_head_data;
                o_cache_write_tag         = w_head_addr[TAG_LSB +: CacheTagWidth];
                o_cache_write_valid       = {BE_W{1'b1}};
            end
            default: begin
            end
        endcase
    end

    // The strobe is forced low while reset is held so that a request still
    // presented by a port cannot reach the cache before reset releases.
    assign o_cache_write_enable = (w_src != WR_SRC_NONE) && i_rst_n;

    // Address bits outside the index/tag fields do not affect the write port.
    assign w_unused_addr = ^{w_dir_req.addr, w_head_addr};

endmodule : cache_write_sequencer
`default_nettype wire

// File: tb/tb_cache_write_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_cache_write_sequencer
//  Purpose : Self-checking bench for cache_write_sequencer. A queue-based
//            reference model predicts every cycle's outputs; directed
//            scenarios cover arbitration, full queue, kill, valid merge,
//            flush and asynchronous reset, followed by random traffic.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_cache_write_sequencer;

    localparam int NP = 3;
    localparam logic [31:0] MMIO = 32'h4000_0000;

    logic              clk;
    logic              rst_n;
    logic              stall;
    logic              flush;
    logic [NP-1:0]     wr_valid;
    logic [NP-1:0][31:0] wr_addr;
    logic [NP-1:0][31:0] wr_data;
    logic [NP-1:0][3:0]  wr_be;
    logic [NP-1:0]     wr_ready;
    logic              fill_valid;
    logic [31:0]       fill_addr;
    logic [31:0]       fill_data;
    logic              fill_ready;
    logic [6:0]        read_tag;
    logic [3:0]        read_valid;
    logic              cw_en;
    logic [3:0]        cw_be;
    logic [6:0]        cw_index;
    logic [31:0]       cw_data;
    logic [6:0]        cw_tag;
    logic [3:0]        cw_valid;
    logic [2:0]        fill_count;

    cache_write_sequencer dut (
        .i_clk                     (clk),
        .i_rst_n                   (rst_n),
        .i_stall                   (stall),
        .i_flush                   (flush),
        .i_wr_valid                (wr_valid),
        .i_wr_addr                 (wr_addr),
        .i_wr_data                 (wr_data),
        .i_wr_be                   (wr_be),
        .o_wr_ready                (wr_ready),
        .i_fill_valid              (fill_valid),
        .i_fill_addr               (fill_addr),
        .i_fill_data               (fill_data),
        .o_fill_ready              (fill_ready),
        .i_cache_read_tag          (read_tag),
        .i_cache_read_valid        (read_valid),
        .o_cache_write_enable      (cw_en),
        .o_cache_byte_write_enable (cw_be),
        .o_cache_write_index       (cw_index),
        .o_cache_write_data        (cw_data),
        .o_cache_write_tag         (cw_tag),
        .o_cache_write_valid       (cw_valid),
        .o_fill_count              (fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  idx;
        logic [6:0]  tag;
        logic [31:0] data;
        bit          killed;
    } fill_t;

    fill_t mq[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] a_idx(input logic [31:0] a);
        return a[8:2];
    endfunction

    function automatic logic [6:0] a_tag(input logic [31:0] a);
        return a[15:9];
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
        return a >= MMIO;
    endfunction

    task automatic clear_inputs();
        stall      = 1'b0;
        flush      = 1'b0;
        wr_valid   = '0;
        wr_addr    = '0;
        wr_data    = '0;
        wr_be      = '0;
        fill_valid = 1'b0;
        fill_addr  = '0;
        fill_data  = '0;
        read_tag   = '0;
        read_valid = '0;
    endtask

    // Predict this cycle's outputs from the current inputs and model queue,
    // compare, then advance the model to the state after the next edge.
    task automatic model_cycle();
        int          g;
        bit          pop;
        bit          fready;
        int          live;
        logic [2:0]  exp_ready;
        logic [3:0]  exp_valid;
        fill_t       e;
        g         = -1;
        exp_ready = '0;
        for (int p = 0; p < NP; p++) begin
            if (wr_valid[p]) begin
                if (wr_be[p] != 4'h0 && !is_mmio(wr_addr[p])) begin
                    if (g < 0) begin
                        g = p;
                        exp_ready[p] = 1'b1;
                    end
                end else begin
                    exp_ready[p] = 1'b1;
                end
            end
        end
        pop    = (g < 0) && !stall && !flush && (mq.size() > 0);
        fready = (mq.size() < 4) || pop;
        live   = 0;
        foreach (mq[i]) if (!mq[i].killed) live++;

        check("wr_ready", wr_ready, exp_ready);
        check("fill_ready", fill_ready, fready);
        check("fill_count", fill_count, live);
        if (g >= 0) begin
            exp_valid = (read_tag == a_tag(wr_addr[g])) ? (wr_be[g] | read_valid) : wr_be[g];
            check("dir_en", cw_en, 1);
            check("dir_be", cw_be, wr_be[g]);
            check("dir_index", cw_index, a_idx(wr_addr[g]));
            check("dir_data", cw_data, wr_data[g]);
            check("dir_tag", cw_tag, a_tag(wr_addr[g]));
            check("dir_valid", cw_valid, exp_valid);
        end else if (pop && !mq[0].killed) begin
            check("fill_en", cw_en, 1);
            check("fill_be", cw_be, 4'hF);
            check("fill_index", cw_index, mq[0].idx);
            check("fill_data", cw_data, mq[0].data);
            check("fill_tag", cw_tag, mq[0].tag);
            check("fill_valid", cw_valid, 4'hF);
        end else begin
            check("idle_en", cw_en, 0);
        end

        if (flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (g >= 0) begin
                foreach (mq[i]) if (mq[i].idx == a_idx(wr_addr[g])) mq[i].killed = 1'b1;
            end
            if (fill_valid && fready && !is_mmio(fill_addr)) begin
                e.idx    = a_idx(fill_addr);
                e.tag    = a_tag(fill_addr);
                e.data   = fill_data;
                e.killed = (g >= 0) && (a_idx(fill_addr) == a_idx(wr_addr[g]));
                mq.push_back(e);
            end
        end
    endtask

    // Called at posedge+1 with inputs applied; returns at the next posedge+1.
    task automatic run_cycle();
        #2;
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 7) == 0) begin
            a = MMIO + ($urandom_range(0, 255) << 2);
        end else begin
            a = '0;
            a[8:2]  = 7'($urandom_range(0, 7));
            a[15:9] = 7'($urandom_range(0, 3));
        end
        return a;
    endfunction

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #1;
        check("rst_en", cw_en, 0);
        check("rst_count", fill_count, 0);
        check("rst_fill_ready", fill_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Ports 0 and 2 compete; port 2 wins the following cycle.
        wr_valid   = 3'b101;
        wr_addr[0] = 32'h100;  wr_data[0] = 32'hAAAA_0000; wr_be[0] = 4'hF;
        wr_addr[2] = 32'h204;  wr_data[2] = 32'hCCCC_2222; wr_be[2] = 4'hF;
        #1;
        check("arb_ready_first", wr_ready, 3'b001);
        check("arb_index_first", cw_index, 7'h40);
        run_cycle();
        wr_valid = 3'b100;
        #1;
        check("arb_ready_second", wr_ready, 3'b100);
        check("arb_index_second", cw_index, 7'h01);
        run_cycle();

        // MMIO and zero-be requests are dropped; the cached port is written.
        clear_inputs();
        wr_valid   = 3'b111;
        wr_addr[0] = MMIO + 32'h10; wr_be[0] = 4'hF;
        wr_addr[1] = 32'h300;       wr_be[1] = 4'h0;
        wr_addr[2] = 32'h308;       wr_be[2] = 4'h5; wr_data[2] = 32'h1234_5678;
        #1;
        check("drop_ready", wr_ready, 3'b111);
        check("drop_index", cw_index, 7'h42);
        run_cycle();

        // Fill the queue, refuse a fifth push, then pop and push together.
        clear_inputs();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fill_valid = 1'b1;
            fill_addr  = 32'h1000 + 32'(i * 4);
            fill_data  = $urandom;
            run_cycle();
        end
        fill_addr = 32'h1010;
        fill_data = $urandom;
        #1;
        check("full_fill_ready", fill_ready, 0);
        check("full_count", fill_count, 4);
        run_cycle();
        stall = 1'b0;
        #1;
        check("full_pop_ready", fill_ready, 1);
        run_cycle();
        check("full_pop_push_count", fill_count, 4);
        clear_inputs();
        flush = 1'b1;
        run_cycle();
        clear_inputs();

        // A store to the index of a queued fill kills that fill.
        stall      = 1'b1;
        fill_valid = 1'b1;
        fill_addr  = 32'h80;
        fill_data  = 32'hDEAD_BEEF;
        run_cycle();
        fill_valid = 1'b0;
        wr_valid   = 3'b010;
        wr_addr[1] = 32'h80;
        wr_data[1] = 32'h0BAD_F00D;
        wr_be[1]   = 4'hF;
        run_cycle();
        check("kill_count", fill_count, 0);
        clear_inputs();
        repeat (3) run_cycle();

        // Valid merge with a matching tag, replacement with a different tag.
        wr_valid   = 3'b001;
        wr_addr[0] = 32'h0000_0A0C;
        wr_data[0] = 32'h5555_AAAA;
        wr_be[0]   = 4'b0011;
        read_tag   = 7'd5;
        read_valid = 4'b1100;
        #1;
        check("merge_valid", cw_valid, 4'b1111);
        check("merge_be", cw_be, 4'b0011);
        run_cycle();
        read_tag = 7'd6;
        #1;
        check("replace_valid", cw_valid, 4'b0011);
        run_cycle();

        // Flush discards queued fills and beats a simultaneous push.
        clear_inputs();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fill_valid = 1'b1;
            fill_addr  = 32'h2000 + 32'(i * 4);
            fill_data  = $urandom;
            run_cycle();
        end
        fill_addr = 32'h200C;
        flush     = 1'b1;
        run_cycle();
        check("flush_count", fill_count, 0);
        clear_inputs();
        repeat (4) run_cycle();

        // Asynchronous reset while fills are queued.
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            fill_valid = 1'b1;
            fill_addr  = 32'h3000 + 32'(i * 4);
            fill_data  = $urandom;
            run_cycle();
        end
        fill_valid = 1'b0;
        check("pre_reset_count", fill_count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_en", cw_en, 0);
        check("async_rst_count", fill_count, 0);
        check("async_rst_ready", fill_ready, 1);
        mq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stall = 1'b0;
        repeat (3) run_cycle();

        // Random traffic against the model.
        repeat (800) begin
            stall      = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 23) == 0);
            for (int p = 0; p < NP; p++) begin
                wr_valid[p] = ($urandom_range(0, 9) < 3);
                wr_addr[p]  = rand_addr();
                wr_data[p]  = $urandom;
                wr_be[p]    = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            fill_valid = ($urandom_range(0, 9) < 6);
            fill_addr  = rand_addr();
            fill_data  = $urandom;
            read_tag   = 7'($urandom_range(0, 3));
            read_valid = 4'($urandom);
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_cache_write_sequencer
`default_nettype wire

// File: doc/cache_write_sequencer.md
CACHE_WRITE_SEQUENCER -- requirements
Module: cache_write_sequencer

Interface
REQ-001 SHALL have parameters: XLEN=32, data width; CacheIndexWidth=7, index bits at addr[2+:CacheIndexWidth]; CacheTagWidth=7, tag bits above the index; NumPorts=3, number of direct write ports, port 0 highest priority; FillDepth=4, deferred-fill queue entries (power of two, >=2); MMIO_ADDR=32'h4000_0000, addresses >= this are uncached.
REQ-002 SHALL have ports (clock and reset first):
- i_clk, in, 1, clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_stall, in, 1, pipeline stall; blocks fill drain.
- i_flush, in, 1, discards all queued fills.
- i_wr_valid, in, NumPorts, direct write request per port.
- i_wr_addr, in, NumPorts x XLEN, byte address per port.
- i_wr_data, in, NumPorts x XLEN, write data per port.
- i_wr_be, in, NumPorts x XLEN/8, byte enables per port.
- o_wr_ready, out, NumPorts, port granted or dropped this cycle.
- i_fill_valid, in, 1, load-miss fill push.
- i_fill_addr, in, XLEN, fill address.
- i_fill_data, in, XLEN, fill word.
- o_fill_ready, out, 1, queue can accept a push.
- i_cache_read_tag, in, CacheTagWidth, tag at the write index.
- i_cache_read_valid, in, XLEN/8, valid bits at the write index.
- o_cache_write_enable, out, 1, cache write strobe.
- o_cache_byte_write_enable, out, XLEN/8, byte strobes.
- o_cache_write_index, out, CacheIndexWidth, write index.
- o_cache_write_data, out, XLEN, write data.
- o_cache_write_tag, out, CacheTagWidth, write tag.
- o_cache_write_valid, out, XLEN/8, new valid bits.
- o_fill_count, out, $clog2(FillDepth+1), live queue occupancy.
REQ-003 SHALL use one clock, i_clk; reset i_rst_n is asynchronous and active-low.

Function
REQ-004 SHALL grant, combinationally and in the same cycle, the lowest-index port with i_wr_valid=1, nonzero i_wr_be and a non-MMIO address.
REQ-005 SHALL assert o_wr_ready for the granted port.
REQ-006 SHALL assert o_wr_ready for any valid port whose address is MMIO or whose i_wr_be is zero, and SHALL NOT write the cache for it.
REQ-007 SHALL hold o_wr_ready low for losing cached ports; they retry the next cycle.
REQ-008 A direct write SHALL drive byte enable = i_wr_be and valid = i_wr_be | i_cache_read_valid when i_cache_read_tag matches the port tag, else i_wr_be.
REQ-009 SHALL enqueue a fill when i_fill_valid and o_fill_ready are both high; MMIO fills SHALL be accepted and discarded.
REQ-010 o_fill_ready SHALL be high when occupancy < FillDepth, or when occupancy = FillDepth and a pop occurs this cycle.
REQ-011 SHALL pop the head entry when no direct grant occurs, i_stall=0, and the queue is non-empty.
REQ-012 A popped live entry SHALL write all bytes with valid = all ones; a popped killed entry SHALL produce no write.
REQ-013 A granted direct write SHALL kill, in the same cycle, every queued entry whose index matches, including a fill being pushed that cycle.
REQ-014 Kill SHALL NOT reorder the queue; o_fill_count SHALL count only live entries.
REQ-015 i_flush SHALL empty the queue next cycle, take priority over a simultaneous push, and not block direct writes.
REQ-016 Read and write pointers SHALL wrap modulo FillDepth.
REQ-017 Fill latency SHALL be at least one cycle after push.

Reset
REQ-018 On i_rst_n=0: pointers, entry valid/kill bits and o_fill_count SHALL be 0; o_cache_write_enable SHALL be 0; o_fill_ready SHALL be 1.
REQ-019 Reset mid-drain SHALL drop all queued fills with no write; data registers need no reset.

Structure
REQ-020 The cache_write_req_t struct (addr, data, be) SHALL be placed in riscv_pkg.
REQ-021 The queue SHALL be the sub-module cache_fill_queue (FIFO with per-entry index-match kill); arbitration SHALL remain in the top module.

Verification
REQ-022 Ports 0 and 2 write addr 0x100 and 0x204 in the same cycle -> port 0 written, o_wr_ready=3'b001; port 2 written the next cycle.
REQ-023 Push 4 fills; a 5th push with no pop -> o_fill_ready=0, o_fill_count=4; a pop and push in the same cycle -> count stays 4.
REQ-024 Fill at 0x80 queued, then port 1 stores to 0x80 -> fill entry killed; no cache write of the fill data ever occurs.
REQ-025 Store be=4'b0011 with matching tag and read_valid=4'b1100 -> o_cache_write_valid=4'b1111.
REQ-026 Push 3 fills, then i_flush -> o_fill_count=0 next cycle; no fill writes occur.
REQ-027 i_rst_n low while 2 fills are queued -> o_cache_write_enable=0 and o_fill_count=0 immediately, without waiting for a clock edge.
